// File: rtl/memory_access_controller_pkg.sv
// Shared types and widths for the memory access controller and its command/response bus.
// Also holds the helper that classifies an operation as a write.
package memory_access_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        READ       = 2'd0,
        WRITE      = 2'd1,
        FILL       = 2'd2,
        READ_BURST = 2'd3
    } op_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    function automatic logic is_write(input op_t op);
        return (op == WRITE) || (op == FILL);
    endfunction

endpackage

// File: rtl/memory_access_controller_if.sv
// Command/response bus between the arithmetic engine (master) and the controller (slave).
interface memory_access_controller_if;
    import memory_access_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    op_t                   cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_address;
    logic [31:0]           cmd_length;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_data;
    logic [ADDR_WIDTH-1:0] resp_address;
    logic                  error;

    modport master (
        output cmd_valid, cmd_op, cmd_address, cmd_length, cmd_data,
        input  cmd_ready, resp_valid, resp_data, resp_address, error
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_address, cmd_length, cmd_data,
        output cmd_ready, resp_valid, resp_data, resp_address, error
    );
endinterface

// File: rtl/memory_block_interface.sv
// Single-port word storage with a registered read port (read data valid one cycle after access).
module memory_block_interface
    import memory_access_pkg::*;
#(
    parameter int unsigned SIZE = 800000
) (
    input  logic                  clock,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_input,
    input  logic                  write_enable,
    output logic [DATA_WIDTH-1:0] read_output
);
    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    // NOTE: the storage array has no reset; clearing it would forbid RAM inference.
    logic [DATA_WIDTH-1:0] mem [SIZE];

    always_ff @(posedge clock) begin
        if (address < SIZE) begin
            if (write_enable) mem[address[IDX_W-1:0]] <= write_input;
            read_output <= mem[address[IDX_W-1:0]];
        end
    end
endmodule

// File: rtl/memory_access_controller.sv
// Front end that turns single/burst read, write and fill commands into one memory access per cycle.
// Read data returns through a one-stage response pipe with no backpressure.
module memory_access_controller
    import memory_access_pkg::*;
#(
    parameter int unsigned SIZE = 800000
) (
    input  logic                          clock,
    input  logic                          reset_n,
    memory_access_controller_if.slave     bus,
    output logic [ADDR_WIDTH-1:0]         mem_address,
    output logic [DATA_WIDTH-1:0]         mem_write_input,
    output logic                          mem_write_enable,
    input  logic [DATA_WIDTH-1:0]         mem_read_output
);
    state_t                state_q, state_d;
    op_t                   op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [31:0]           remain_q, remain_d;
    logic                  error_q, error_d;
    logic                  resp_valid_q;
    logic [ADDR_WIDTH-1:0] resp_addr_q;

    logic                  accept;
    logic                  bad_cmd;
    logic                  rd_issued;
    logic [31:0]           eff_len;
    logic [32:0]           end_addr;

    assign bus.cmd_ready = (state_q == IDLE) && reset_n;
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    // Single-word ops ignore cmd_length; the range check runs at 33 bits so it cannot wrap.
    always_comb begin
        eff_len  = ((bus.cmd_op == READ) || (bus.cmd_op == WRITE)) ? 32'd1 : bus.cmd_length;
        end_addr = {1'b0, bus.cmd_address} + {1'b0, eff_len};
        bad_cmd  = (eff_len == 32'd0) || (end_addr > 33'(SIZE));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // NOTE: every signal gets a default first so no path through the block infers a latch.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        data_d   = data_q;
        remain_d = remain_q;
        error_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bad_cmd) begin
                        error_d = 1'b1;
                    end else begin
                        state_d  = ACTIVE;
                        op_d     = bus.cmd_op;
                        addr_d   = bus.cmd_address;
                        data_d   = bus.cmd_data;
                        remain_d = eff_len;
                    end
                end
            end
            ACTIVE: begin
                addr_d   = addr_q + 32'd1;
                remain_d = remain_q - 32'd1;
                if (remain_q == 32'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Idle drives address 0; the resulting read of word 0 is never reported.
    always_comb begin
        mem_address      = '0;
        mem_write_input  = '0;
        mem_write_enable = 1'b0;
        rd_issued        = 1'b0;
        if (state_q == ACTIVE) begin
            mem_address      = addr_q;
            mem_write_input  = data_q;
            mem_write_enable = is_write(op_q);
            rd_issued        = !is_write(op_q);
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q         <= READ;
            addr_q       <= '0;
            data_q       <= '0;
            remain_q     <= '0;
            error_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_addr_q  <= '0;
        end else begin
            op_q         <= op_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            remain_q     <= remain_d;
            error_q      <= error_d;
            resp_valid_q <= rd_issued;
            if (rd_issued) resp_addr_q <= addr_q;
        end
    end

    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_data    = mem_read_output;
    assign bus.resp_address = resp_addr_q;
    assign bus.error        = error_q;
endmodule

// File: tb/tb_memory_access_controller.sv
// Scoreboard bench: commands push expected read responses; a negedge monitor pops and compares.
module tb_memory_access_controller;
    import memory_access_pkg::*;

    localparam int unsigned SIZE = 64;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] mem_address, mem_write_input, mem_read_output;
    logic        mem_write_enable;

    always #5 clock = ~clock;

    memory_access_controller_if bus ();

    memory_access_controller #(.SIZE(SIZE)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .bus             (bus),
        .mem_address     (mem_address),
        .mem_write_input (mem_write_input),
        .mem_write_enable(mem_write_enable),
        .mem_read_output (mem_read_output)
    );

    memory_block_interface #(.SIZE(SIZE)) mem (
        .clock       (clock),
        .address     (mem_address),
        .write_input (mem_write_input),
        .write_enable(mem_write_enable),
        .read_output (mem_read_output)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] model [SIZE];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          err_cnt = 0;
    int          we_cnt = 0;
    int          last_err_cyc = -1;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (bus.error) begin
            err_cnt++;
            last_err_cyc = cyc;
        end
        if (mem_write_enable) we_cnt++;
        if (bus.resp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected resp_valid", 32'(bus.resp_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_address", bus.resp_address, mon_e.addr);
                check("resp_data", bus.resp_data, mon_e.data);
                check("resp cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    // Presents a command, waits (bounded) for acceptance, then updates the model / scoreboard.
    task automatic issue(input op_t op, input logic [31:0] addr, input logic [31:0] len,
                         input logic [31:0] data, input bit upd, output int t);
        logic [31:0] eff;
        logic [32:0] endp;
        int          n;
        bus.cmd_op      = op;
        bus.cmd_address = addr;
        bus.cmd_length  = len;
        bus.cmd_data    = data;
        bus.cmd_valid   = 1'b1;
        n = 0;
        @(negedge clock);
        while (!bus.cmd_ready && n < 50) begin
            n++;
            @(negedge clock);
        end
        if (!bus.cmd_ready) check("cmd_ready timeout", 32'(bus.cmd_ready), 32'd1);
        t = cyc;
        @(posedge clock);
        #1 bus.cmd_valid = 1'b0;
        eff  = ((op == READ) || (op == WRITE)) ? 32'd1 : len;
        endp = {1'b0, addr} + {1'b0, eff};
        if (eff != 0 && endp <= 33'(SIZE)) begin
            for (int i = 0; i < int'(eff); i++) begin
                if ((op == WRITE || op == FILL) && upd) model[addr + 32'(i)] = data;
                if (op == READ || op == READ_BURST)
                    exp_q.push_back('{addr + 32'(i), model[addr + 32'(i)], t + 2 + i});
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(negedge clock);
        end
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int t, t2, e0, w0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = READ;
        bus.cmd_address = '0;
        bus.cmd_length  = '0;
        bus.cmd_data    = '0;

        repeat (3) @(posedge clock);
        #1;
        check("reset cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
        check("reset error", 32'(bus.error), 32'd0);
        check("reset mem_write_enable", 32'(mem_write_enable), 32'd0);
        check("reset mem_address", mem_address, 32'd0);
        check("reset mem_write_input", mem_write_input, 32'd0);
        check("reset resp_address", bus.resp_address, 32'd0);
        reset_n = 1'b1;
        #1 check("cmd_ready after release", 32'(bus.cmd_ready), 32'd1);

        for (int i = 0; i < int'(SIZE); i++) issue(WRITE, 32'(i), 32'd0, 32'h1000 + 32'(i), 1'b1, t);

        // Write then read back with two-cycle latency.
        issue(WRITE, 32'd5, 32'd1, 32'hDEADBEEF, 1'b1, t);
        issue(READ, 32'd5, 32'd0, 32'd0, 1'b1, t);
        drain();

        // Fill four words, then a burst straddling both edges of the fill.
        issue(FILL, 32'd10, 32'd4, 32'h7, 1'b1, t);
        issue(READ_BURST, 32'd9, 32'd6, 32'd0, 1'b1, t);
        drain();

        // Rejected commands: zero length and out of range.
        e0 = err_cnt;
        w0 = we_cnt;
        issue(FILL, 32'd3, 32'd0, 32'h55, 1'b1, t);
        check("ready after zero-length reject", 32'(bus.cmd_ready), 32'd1);
        repeat (2) @(posedge clock);
        #1;
        check("zero-length error count", 32'(err_cnt), 32'(e0 + 1));
        check("zero-length error cycle", 32'(last_err_cyc), 32'(t + 1));
        issue(READ_BURST, 32'd60, 32'd5, 32'd0, 1'b1, t);
        check("ready after range reject", 32'(bus.cmd_ready), 32'd1);
        repeat (2) @(posedge clock);
        #1;
        check("range error count", 32'(err_cnt), 32'(e0 + 2));
        check("range error cycle", 32'(last_err_cyc), 32'(t + 1));
        check("no writes on reject", 32'(we_cnt), 32'(w0));
        issue(READ, 32'd3, 32'd0, 32'd0, 1'b1, t);
        issue(READ_BURST, 32'd56, 32'd8, 32'd0, 1'b1, t);
        drain();

        // Burst followed by a held WRITE: accepted exactly when the burst's last response appears.
        issue(READ_BURST, 32'd30, 32'd3, 32'd0, 1'b1, t);
        check("ready low during burst", 32'(bus.cmd_ready), 32'd0);
        issue(WRITE, 32'd31, 32'd1, 32'hCAFE0001, 1'b1, t2);
        check("back-to-back accept cycle", 32'(t2), 32'(t + 4));
        issue(READ, 32'd31, 32'd0, 32'd0, 1'b1, t);
        drain();

        // Reset during the third cycle of an 8-word fill: only two words land.
        e0 = err_cnt;
        w0 = we_cnt;
        issue(FILL, 32'd20, 32'd8, 32'hAA, 1'b0, t);
        model[20] = 32'hAA;
        model[21] = 32'hAA;
        @(posedge clock);
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        check("cmd_ready in reset", 32'(bus.cmd_ready), 32'd0);
        check("write_enable in reset", 32'(mem_write_enable), 32'd0);
        check("resp_valid in reset", 32'(bus.resp_valid), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        #1;
        check("cmd_ready after mid-burst reset", 32'(bus.cmd_ready), 32'd1);
        check("writes before reset", 32'(we_cnt), 32'(w0 + 2));
        check("no error across reset", 32'(err_cnt), 32'(e0));
        issue(READ_BURST, 32'd19, 32'd5, 32'd0, 1'b1, t);
        drain();

        // Streaming: READ of word 0 accepted the cycle ready returns after a WRITE to it.
        issue(WRITE, 32'd0, 32'd1, 32'd1, 1'b1, t);
        issue(READ, 32'd0, 32'd0, 32'd0, 1'b1, t2);
        check("streaming accept cycle", 32'(t2), 32'(t + 2));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/memory_access_controller.md
# memory_access_controller

Initiator-side front end for the single-port `memory_block_interface` storage. It accepts single and burst read/write/fill commands over a valid/ready handshake and drives the memory's address, write data and write-enable, issuing at most one access per cycle. Read data returns to the client as a response stream. It sits between the pi-digit arithmetic engine and the big digit array.

## Interface
- `SIZE`, 800000, number of 32-bit words in the attached memory; used for range checking.
- `clock`  input  1  system clock, rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `cmd_valid`  input  1  command present.
- `cmd_ready`  output  1  controller can accept a command.
- `cmd_op`  input  2  0 = READ, 1 = WRITE, 2 = FILL, 3 = READ_BURST.
- `cmd_address`  input  32  first word address.
- `cmd_length`  input  32  word count for FILL and READ_BURST; ignored (treated as 1) for READ and WRITE.
- `cmd_data`  input  32  write data (WRITE) or fill constant (FILL).
- `resp_valid`  output  1  `resp_data` and `resp_address` are valid this cycle; no backpressure.
- `resp_data`  output  32  read word.
- `resp_address`  output  32  address the word was read from.
- `error`  output  1  one-cycle pulse when a command is rejected.
- `mem_address`  output  32  to memory `address`.
- `mem_write_input`  output  32  to memory `write_input`.
- `mem_write_enable`  output  1  to memory `write_enable`.
- `mem_read_output`  input  32  from memory `read_output`; registered, valid 1 cycle after a read access.

## Operation
- States: IDLE and ACTIVE.
- `cmd_ready` = (state == IDLE) && `reset_n`.
- A command is accepted on a cycle where `cmd_valid && cmd_ready`. On acceptance, latch op, address, data and the effective length (1 for READ/WRITE).
- Rejection, in IDLE:
  - Effective length is 0, or `cmd_address + length > SIZE` (computed at 33 bits).
  - Response: `error` = 1 for the next cycle, no memory access, state stays IDLE.
- ACTIVE, each cycle:
  - Drive `mem_address` = current address register.
  - Drive `mem_write_enable` = 1 for WRITE/FILL, 0 for reads; `mem_write_input` = latched data.
  - Increment the address register and decrement the remaining count.
  - When remaining == 1 at the issue cycle, return to IDLE next cycle.
- IDLE: `mem_write_enable` = 0, `mem_address` = 0, `mem_write_input` = 0. The memory's idle read of word 0 is harmless.
- Response pipe, one register stage:
  - `rd_issued` and `rd_addr` capture each read issue.
  - `resp_valid` = `rd_issued` delayed 1 cycle; `resp_data` = `mem_read_output`; `resp_address` = `rd_addr`.
- Responses of a finishing burst may overlap acceptance of the next command. This is legal because responses are a pure pipeline.
- Reset mid-burst: state goes to IDLE immediately, no further memory writes, and a pending `resp_valid` is cleared.
- Reset values: `cmd_ready` 0 while reset is held, 1 after release; `resp_valid` 0; `resp_data` follows memory; `resp_address` 0; `error` 0; `mem_write_enable` 0; `mem_address` 0; `mem_write_input` 0.

## Timing
Command accepted at cycle t:
- READ: memory access at t+1; `resp_valid` at t+2; `cmd_ready` high again at t+2.
- WRITE: `mem_write_enable` high at t+1; `cmd_ready` high at t+2.
- FILL of N words: writes at t+1..t+N; `cmd_ready` high at t+N+1.
- READ_BURST of N words: accesses at t+1..t+N; responses at t+2..t+N+1, one per cycle, in increasing address order; `cmd_ready` high at t+N+1.
- Rejected command: `error` pulses at t+1; `cmd_ready` stays high.
- Back-to-back: a new command can be accepted in the same cycle the last burst response appears.
- Throughput is one word per cycle.

## Structure
- Package `memory_access_pkg`:
  - `op_t` enum: READ, WRITE, FILL, READ_BURST.
  - `state_t` enum: IDLE, ACTIVE.
  - `ADDR_WIDTH` = 32, `DATA_WIDTH` = 32.
- Single module; no sub-module. The bench instantiates this module together with `memory_block_interface` (`SIZE` = 64).

## Test plan
- WRITE 0xDEADBEEF to address 5, then READ 5 → `resp_valid` 2 cycles after acceptance with `resp_data` = 0xDEADBEEF and `resp_address` = 5.
- FILL address 10, length 4, data 0x7 → then READ_BURST address 9, length 6 returns {prior word 9, 7, 7, 7, 7, prior word 14} on 6 consecutive cycles, with `resp_address` 9..14.
- FILL of length 0, and READ_BURST address 60 length 5 with `SIZE` = 64 → `error` pulses once each, `mem_write_enable` never asserts, and memory is unchanged.
- READ_BURST of 3 followed by a WRITE presented with `cmd_valid` held → WRITE accepted exactly at t+4, `cmd_ready` low for t+1..t+3, and the WRITE lands correctly.
- Assert `reset_n` low during the 3rd cycle of a FILL of 8 at address 20 → only words 20..21 written, `resp_valid` and `error` stay 0, and `cmd_ready` returns 1 after release.
- Streaming: WRITE address 0 data 1, then READ 0 accepted the cycle `cmd_ready` returns → read returns 1, with no stale data from the earlier idle read of word 0.
